// File: rtl/soma_sched_pkg.sv
// rtl/soma_sched_pkg.sv - shared FSM state type and default widths for soma_scheduler
package soma_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CLEAR = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int NNW_DEF        = 12;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FAW_DEF        = 3;

endpackage

// File: rtl/soma_scheduler_sync_fifo.sv
// rtl/soma_scheduler_sync_fifo.sv - sync_fifo: first-word-fall-through FIFO with occupancy count
module sync_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/soma_scheduler.sv
// rtl/soma_scheduler.sv - timestep scan / Vm clear sequencer with spike FIFO; option SOMA_SCHED_SPK_CNT_EN
module soma_scheduler
  import soma_sched_pkg::*;
#(
  parameter int NNW        = NNW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FAW        = FAW_DEF
) (
  input  logic           clk_soma,
  input  logic           rst,
  input  logic           tick,
  input  logic           clear_req,
  input  logic [NNW-1:0] neuron_num,
  output logic           busy,
  output logic           done,
  output logic           tick_overrun,
  output logic           config_soma_vld,
  output logic [NNW-1:0] config_soma_vm_addr,
  output logic           config_soma_clear,
  output logic           sd_rd_en,
  output logic [NNW-1:0] sd_rd_addr,
  input  logic           soma_spk_out_fire,
  output logic           spk_valid,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_ready,
`ifdef SOMA_SCHED_SPK_CNT_EN
  output logic [NNW:0]   spk_cnt,
`endif
  input  logic           host_req,
  output logic           host_gnt
);

  localparam logic [FAW+1:0] DEPTH_W = (FAW+2)'(FIFO_DEPTH);

  state_e         state_q;
  logic [NNW-1:0] addr_q;
  logic [NNW-1:0] num_q;
  logic           done_q;
  logic           overrun_q;
  logic           inflight_q;
  logic [NNW-1:0] inflight_addr_q;

  logic [FAW:0]   fifo_count;
  logic [FAW+1:0] occupancy;
  logic           room;
  logic           issue_scan;
  logic           issue_clear;
  logic           last_addr;
  logic           start_scan;
  logic           start_clear;
  logic           drop;
  logic           fifo_push;
  logic           fifo_pop;

  // A scan strobe is only issued when its possible spike, plus the one still in flight, fits.
  assign occupancy   = {1'b0, fifo_count} + {{(FAW+1){1'b0}}, inflight_q};
  assign room        = (occupancy < DEPTH_W);
  assign issue_scan  = (state_q == SCAN) && room;
  assign issue_clear = (state_q == CLEAR);
  assign last_addr   = (addr_q == (num_q - NNW'(1)));

  // Clear wins over tick in IDLE; anything arriving outside IDLE is lost and flagged.
  assign start_clear = (state_q == IDLE) && clear_req;
  assign start_scan  = (state_q == IDLE) && tick && !clear_req;
  assign drop        = (state_q != IDLE) ? (tick || clear_req) : (tick && clear_req);

  // Sweep sequencer: address counter, latched sweep length, done pulse and sticky overrun.
  always_ff @(posedge clk_soma) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      num_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (drop) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_clear || start_scan) begin
            addr_q <= '0;
            num_q  <= neuron_num;
            if (neuron_num == '0) state_q <= DRAIN;
            else                  state_q <= start_clear ? CLEAR : SCAN;
          end
        end
        SCAN, CLEAR: begin
          if (issue_scan || issue_clear) begin
            if (last_addr) state_q <= DRAIN;
            else           addr_q  <= addr_q + NNW'(1);
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Remember the previous scan strobe so its fire result can be matched to its address.
  always_ff @(posedge clk_soma) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q      <= issue_scan;
      inflight_addr_q <= addr_q;
    end
  end

  assign fifo_push = inflight_q && soma_spk_out_fire;
  assign fifo_pop  = spk_valid && spk_ready;

  sync_fifo #(
    .W     (NNW),
    .DEPTH (FIFO_DEPTH),
    .AW    (FAW)
  ) u_spk_fifo (
    .clk_i   (clk_soma),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (inflight_addr_q),
    .pop_i   (fifo_pop),
    .rdata_o (spk_addr),
    .valid_o (spk_valid),
    .count_o (fifo_count)
  );

`ifdef SOMA_SCHED_SPK_CNT_EN
  logic [NNW:0] spk_cnt_q;

  // Saturating count of fires captured since the most recent scan started.
  always_ff @(posedge clk_soma) begin
    if (rst || start_scan) begin
      spk_cnt_q <= '0;
    end else if (fifo_push && (spk_cnt_q != '1)) begin
      spk_cnt_q <= spk_cnt_q + (NNW+1)'(1);
    end
  end

  assign spk_cnt = spk_cnt_q;
`endif

  assign busy                = (state_q != IDLE);
  assign done                = done_q;
  assign tick_overrun        = overrun_q;
  assign config_soma_vld     = issue_scan || issue_clear;
  assign config_soma_vm_addr = addr_q;
  assign config_soma_clear   = (state_q == CLEAR);
  assign sd_rd_en            = issue_scan;
  assign sd_rd_addr          = addr_q;
  assign host_gnt            = host_req && (state_q == IDLE) && !tick && !clear_req;

endmodule
